wallace_mult_pipe: RTL
======================

// Module: wallace_mult_pipe
// PURPOSE
//  Parametrised, DSP-free Wallace-tree multiplier with a fixed 3-stage pipeline.
//  Each transaction selects signed or unsigned mode (per-op tc flag) and carries an opaque tag.
//  Full valid/ready backpressure allows use inside stalling vector-MAC lanes.
//  Drop-in successor for the int8 lane multiplier; the vec-MAC accumulator consumes its output.
// PARAMETERS
//  WIDTH   8   operand width in bits (>=4); product is 2*WIDTH bits
//  TAG_W   4   sideband tag width (>=1), carried unmodified alongside the op
// PORTS
//  clk        in   1          rising-edge clock
//  rst_n      in   1          asynchronous active-low reset
//  in_valid   in   1          operand beat valid
//  in_ready   out  1          block can accept a beat this cycle
//  in_tc      in   1          1 = two's-complement operands, 0 = unsigned
//  in_tag     in   TAG_W      sideband, returned with the product
//  a          in   WIDTH      multiplicand
//  b          in   WIDTH      multiplier
//  out_valid  out  1          product beat valid
//  out_ready  in   1          downstream accepts beat
//  out_tag    out  TAG_W      tag of the current product
//  product    out  2*WIDTH    a*b, exact, in the mode of in_tc
// BEHAVIOUR
//  Reset: v1/v2/v3 = 0; out_valid = 0, product = 0, out_tag = 0; in_ready = 1 once rst_n high.
//  Pipeline: S1 PP gen + first CSA layer -> reg; S2 CSA reduction -> reg; S3 final CPA -> output reg.
//  Accept: beat taken on cycle where in_valid && in_ready. Product appears 3 cycles later with no stall.
//  Stall: stage k loads when !vk || advance_k; advance_3 = out_ready; advance_k = !v(k+1) || advance_(k+1).
//  in_ready = !v1 || advance_1 (combinational from out_ready through bubbles; no skid buffer).
//  Bubbles collapse: a free stage loads even when a later stage is stalled.
//  Hold: while out_valid && !out_ready, product/out_tag/out_valid stay stable. Same for stalled stages.
//  Throughput: 1 beat/cycle while out_ready = 1. No beat is dropped or duplicated. Order is preserved.
//  Unsigned (tc=0): product = a*b, range 0..(2^WIDTH-1)^2.
//  Signed (tc=1): Baugh-Wooley partial products. product = a*b as 2*WIDTH-bit two's complement.
//  Signed corner: (-2^(W-1))^2 = 2^(2W-2) fits, so no overflow and no saturation.
//  tc and tag ride the pipeline with their operands. Mixed modes back-to-back are legal.
//  Unused data regs may load X-free garbage when vk = 0. Outputs must be 0 until the first valid beat.
//  Reset mid-op: all in-flight beats are discarded. Valids clear immediately (async). No output follows.
//  Simultaneous in accept + out pop on a full pipe: both happen; occupancy stays 3.
//  No `*` operator in the datapath; pure FA/HA tree + final adder (use_dsp = "no").
// TESTING
//  T1 unsigned W=8: a=255,b=255,tc=0, out_ready=1 -> product 0xFE01 exactly 3 cycles after accept.
//  T2 signed W=8: a=0x80,b=0x80 -> 0x4000; a=0x80,b=0x7F -> 0xC080; a=0xFF,b=0x01 -> 0xFFFF.
//  T3 streaming: 16 back-to-back beats with tags 0..15 and mixed tc -> 16 outputs, 1/cycle, tags in order.
//  T4 backpressure: fill the pipe, hold out_ready=0 for 5 cycles -> in_ready=0 after 3 accepts;
//     product/tag stable; release -> all 3 beats in order, none lost.
//  T5 bubble: beat, 2 idle cycles, beat, with out_ready=0 -> both compact into S3/S2. in_ready stays 1 until full.
//  T6 reset: assert rst_n=0 mid-stream with 3 beats in flight -> out_valid=0, product=0 at once; nothing emitted after release.
//     Also run the random signed/unsigned reference-model check at WIDTH=8 and WIDTH=12.

Source files
------------

// File: rtl/wallace_mult_pipe.sv
// Three-stage Wallace-tree multiplier (signed/unsigned per beat) with valid/ready flow control.
// S1: partial products + first CSA layer, S2: CSA reduction to two rows, S3: final carry-propagate add.
module wallace_mult_pipe #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned TAG_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_tc,
   input  logic [TAG_W-1:0]   in_tag,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [TAG_W-1:0]   out_tag,
   output logic [2*WIDTH-1:0] product
);

   localparam int unsigned PW = 2 * WIDTH;
   localparam int unsigned N  = WIDTH + 1;
   localparam int unsigned R0 = WIDTH + 2;
   localparam int unsigned R1 = 2 * (R0 / 3) + R0 % 3;

   typedef logic [R0-1:0][PW-1:0] rows_t;

   // One Wallace layer: every full group of three rows becomes sum + shifted carry.
   function automatic rows_t csa_layer(input rows_t r, input int unsigned n);
      rows_t       o;
      int unsigned g3;
      o  = '0;
      g3 = n / 3;
      for (int unsigned g = 0; g < R0 / 3; g++) begin
         if (g < g3) begin
            o[2*g]   = r[3*g] ^ r[3*g+1] ^ r[3*g+2];
            o[2*g+1] = ((r[3*g] & r[3*g+1]) | (r[3*g] & r[3*g+2]) |
                        (r[3*g+1] & r[3*g+2])) << 1;
         end
      end
      for (int unsigned i = 0; i < 2; i++) begin
         if (i < n % 3) o[2*g3+i] = r[3*g3+i];
      end
      return o;
   endfunction

   logic             v1_q, v2_q, v3_q;
   logic             v1_d, v2_d, v3_d;
   logic             adv1, adv2, adv3;
   logic             ld1, ld2, ld3;
   rows_t            rows1_q, rows1_d;
   logic [PW-1:0]    sum_q, sum_d, car_q, car_d;
   logic [PW-1:0]    prod_q, prod_d;
   logic [TAG_W-1:0] tag1_q, tag2_q, tag3_q;
   logic [N-1:0]     xa, yb;
   rows_t            pp, red;
   int unsigned      nrows;

   // Stall chain: a stage advances if its successor is empty or advancing itself.
   always_comb begin
      adv3     = out_ready;
      adv2     = !v3_q || adv3;
      adv1     = !v2_q || adv2;
      in_ready = !v1_q || adv1;
      ld1      = in_ready;
      ld2      = !v2_q || adv2;
      ld3      = !v3_q || adv3;
      v1_d     = ld1 ? in_valid : v1_q;
      v2_d     = ld2 ? v1_q     : v2_q;
      v3_d     = ld3 ? v2_q     : v3_q;
   end

   // Baugh-Wooley on (WIDTH+1)-bit operands; unsigned mode zero-extends, signed sign-extends.
   always_comb begin
      pp = '0;
      xa = {in_tc & a[WIDTH-1], a};
      yb = {in_tc & b[WIDTH-1], b};
      for (int unsigned i = 0; i < N; i++) begin
         for (int unsigned j = 0; j < N; j++) begin
            if (i + j < PW) pp[i][i+j] = (xa[i] & yb[j]) ^ ((i == N - 1) != (j == N - 1));
         end
      end
      pp[N][WIDTH+1] = 1'b1;
      rows1_d = csa_layer(pp, R0);
   end

   always_comb begin
      red   = rows1_q;
      nrows = R1;
      for (int unsigned l = 0; l < R0; l++) begin
         if (nrows > 2) begin
            red   = csa_layer(red, nrows);
            nrows = 2 * (nrows / 3) + nrows % 3;
         end
      end
      sum_d = red[0];
      car_d = red[1];
   end

   assign prod_d = sum_q + car_q;

   // Data registers only load real beats so outputs stay zero until the first product.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q    <= 1'b0;
         v2_q    <= 1'b0;
         v3_q    <= 1'b0;
         rows1_q <= '0;
         sum_q   <= '0;
         car_q   <= '0;
         prod_q  <= '0;
         tag1_q  <= '0;
         tag2_q  <= '0;
         tag3_q  <= '0;
      end else begin
         v1_q <= v1_d;
         v2_q <= v2_d;
         v3_q <= v3_d;
         if (ld1 && in_valid) begin
            rows1_q <= rows1_d;
            tag1_q  <= in_tag;
         end
         if (ld2 && v1_q) begin
            sum_q  <= sum_d;
            car_q  <= car_d;
            tag2_q <= tag1_q;
         end
         if (ld3 && v2_q) begin
            prod_q <= prod_d;
            tag3_q <= tag2_q;
         end
      end
   end

   assign out_valid = v3_q;
   assign out_tag   = tag3_q;
   assign product   = prod_q;

endmodule
